// File: rtl/cross_product_issuer.sv
// Issues operand pairs into the fixed-latency cross_product pipeline and collects
// results into a first-word-fall-through FIFO, with credits so no result is dropped.
module cross_product_issuer #(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [95:0]      in_a,
  input  logic [95:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [95:0]      pipe_a,
  output logic [95:0]      pipe_b,
  input  logic [95:0]      pipe_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [95:0]      out_c,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

  logic [LATENCY:0]     vld_sr_reg;
  logic [TAG_W-1:0]     tag_sr_reg [LATENCY+1];
  logic [95:0]          pipe_a_reg, pipe_b_reg;
  logic [95+TAG_W:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [CNT_W-1:0]     inflight, used;
  logic                 acc, arr, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_sr_reg[i]);
    end
  end

  // Every accepted op owns a FIFO slot from issue until it is popped.
  assign used      = count_reg + inflight;
  assign in_ready  = rst_n & (used < CNT_W'(FIFO_DEPTH));
  assign out_valid = rst_n & (count_reg != '0);

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign arr = vld_sr_reg[LATENCY];

  assign pipe_a = pipe_a_reg;
  assign pipe_b = pipe_b_reg;

  always_comb begin
    count_next = count_reg;
    if (arr && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!arr && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr_reg <= '0;
      pipe_a_reg <= '0;
      pipe_b_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      vld_sr_reg <= {vld_sr_reg[LATENCY-1:0], acc};
      if (acc) begin
        pipe_a_reg <= in_a;
        pipe_b_reg <= in_b;
      end
      if (arr) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_next;
    end
  end

  // Tags only matter where the matching valid bit is set, so they need no reset.
  always_ff @(posedge clk) begin
    tag_sr_reg[0] <= in_tag;
    for (int i = 1; i <= LATENCY; i++) begin
      tag_sr_reg[i] <= tag_sr_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && arr) begin
      mem[wr_ptr_reg] <= {pipe_c, tag_sr_reg[LATENCY]};
    end
  end

  assign {out_c, out_tag} = mem[rd_ptr_reg];

endmodule

// File: tb/tb_cross_product_issuer.sv
// Scoreboard bench for cross_product_issuer with a behavioural model of the
// external fixed-latency cross_product pipeline.
module tb_cross_product_issuer;

  localparam int LAT   = 10;
  localparam int DEPTH = 16;
  localparam int TW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [95:0]   in_a, in_b;
  logic [TW-1:0] in_tag;
  logic [95:0]   pipe_a, pipe_b, pipe_c;
  logic          out_valid, out_ready;
  logic [95:0]   out_c;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  cross_product_issuer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag)
  );

  typedef struct {
    logic [95:0]   c;
    logic [TW-1:0] tag;
    int            cyc;
  } sb_t;

  sb_t        sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cycle   = 0;
  int         n_acc   = 0;
  int         n_pop   = 0;
  bit         acc_seen   = 1'b0;
  bit         lat_chk    = 1'b0;
  bit         stream_chk = 1'b0;
  bit         auto_gen   = 1'b0;
  int         ia[3];
  int         ib[3];
  logic [7:0] seq = 8'h00;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Exact small integers as IEEE single; keeps the float cross product bit-exact.
  function automatic logic [31:0] i2f(input int v);
    int   m;
    int   e;
    logic s;
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (m[i]) e = i;
    return {s, 8'(127 + e), 23'(m << (23 - e))};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int m;
    int v;
    if (f[30:23] == 8'h00) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]});
    v = m >> (23 - e);
    return f[31] ? -v : v;
  endfunction

  function automatic logic [95:0] cross3(input int ax, input int ay, input int az,
                                         input int bx, input int by, input int bz);
    return {i2f(ay*bz - az*by), i2f(az*bx - ax*bz), i2f(ax*by - ay*bx)};
  endfunction

  function automatic logic [95:0] cross_f(input logic [95:0] a, input logic [95:0] b);
    return cross3(f2i(a[95:64]), f2i(a[63:32]), f2i(a[31:0]),
                  f2i(b[95:64]), f2i(b[63:32]), f2i(b[31:0]));
  endfunction

  // External pipeline: result for the operands presented LAT cycles earlier.
  logic [95:0] pd [LAT];
  always @(posedge clk) begin
    pd[0] <= cross_f(pipe_a, pipe_b);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign pipe_c = pd[LAT-1];

  // Handshakes are resolved mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    sb_t e;
    acc_seen = 1'b0;
    cycle++;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (stream_chk && in_valid) check("stream_ready", in_ready, 1);
      if (in_valid && in_ready) begin
        e.c   = cross3(ia[0], ia[1], ia[2], ib[0], ib[1], ib[2]);
        e.tag = in_tag;
        e.cyc = cycle;
        sb.push_back(e);
        check("credit_bound", (sb.size() <= DEPTH), 1);
        acc_seen = 1'b1;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_c", out_c, e.c);
          check("out_tag", out_tag, e.tag);
          if (lat_chk) check("latency", cycle - e.cyc, LAT + 2);
        end
      end
    end
  end

  task automatic set_ops(input int ax, input int ay, input int az,
                         input int bx, input int by, input int bz, input logic [7:0] t);
    ia[0] = ax; ia[1] = ay; ia[2] = az;
    ib[0] = bx; ib[1] = by; ib[2] = bz;
    in_a   = {i2f(ax), i2f(ay), i2f(az)};
    in_b   = {i2f(bx), i2f(by), i2f(bz)};
    in_tag = t;
  endtask

  task automatic gen_ops();
    int r[6];
    for (int k = 0; k < 6; k++) r[k] = int'($urandom_range(200)) - 100;
    set_ops(r[0], r[1], r[2], r[3], r[4], r[5], seq);
    seq++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (acc_seen && auto_gen) gen_ops();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 300 && sb.size() != 0; k++) cyc();
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int base;
    int basep;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 8'h00);
    repeat (3) cyc();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_pipe_a", pipe_a, 0);
    check("rst_pipe_b", pipe_b, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single op (1,0,0) x (0,1,0) = (0,0,1)
    base = n_pop;
    set_ops(1, 0, 0, 0, 1, 0, 8'h5A);
    out_ready = 1'b1; in_valid = 1'b1; lat_chk = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) cyc();
    check("single_valid", out_valid, 1);
    check("single_c", out_c, 96'h3F800000);
    check("single_tag", out_tag, 8'h5A);
    repeat (LAT + 4) cyc();
    check("single_beats", n_pop - base, 1);

    // Back-to-back streaming
    auto_gen = 1'b1; gen_ops();
    stream_chk = 1'b1; in_valid = 1'b1; base = n_acc;
    for (int k = 0; k < 200 && n_acc - base < 64; k++) cyc();
    in_valid = 1'b0; stream_chk = 1'b0;
    check("stream_acc", n_acc - base, 64);
    drain();
    lat_chk = 1'b0;

    // Backpressure fill
    out_ready = 1'b0; in_valid = 1'b1; base = n_acc;
    repeat (30) cyc();
    check("fill_acc", n_acc - base, DEPTH);
    check("fill_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (LAT + 2) cyc();
    check("fill_valid", out_valid, 1);
    check("fill_ready_hold", in_ready, 0);
    basep = n_pop;
    drain();
    check("fill_drain", n_pop - basep, DEPTH);
    check("refill_ready", in_ready, 1);

    // Accept and pop together at full credit, wrapping the pointers
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (20) cyc();
    out_ready = 1'b1; base = n_acc;
    for (int k = 0; k < 400 && n_acc - base < 40; k++) cyc();
    check("credit_acc", n_acc - base, 40);
    drain();

    // Reset with 3 results in the FIFO and 5 in flight
    out_ready = 1'b0; in_valid = 1'b1; base = n_acc;
    for (int k = 0; k < 50 && n_acc - base < 3; k++) cyc();
    in_valid = 1'b0;
    repeat (LAT + 4) cyc();
    check("mid_fifo_valid", out_valid, 1);
    in_valid = 1'b1; base = n_acc;
    for (int k = 0; k < 50 && n_acc - base < 5; k++) cyc();
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    cyc();
    rst_n = 1'b1; out_ready = 1'b1; basep = n_pop;
    repeat (LAT + 6) cyc();
    check("mid_no_stale", n_pop - basep, 0);
    check("mid_out_valid", out_valid, 0);
    lat_chk = 1'b1; gen_ops(); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) cyc();
    check("mid_new_valid", out_valid, 1);
    drain();
    lat_chk = 1'b0;

    // Random valid/ready stalls
    base = n_acc; basep = n_pop;
    for (int k = 0; k < 20000 && n_acc - base < 1000; k++) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      cyc();
    end
    drain();
    check("rand_acc", n_acc - base, 1000);
    check("rand_pop", n_pop - basep, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cross_product_issuer.md
# cross_product_issuer

Initiator/collector for the fixed-latency, non-stallable `cross_product` pipeline in the ray–triangle intersection datapath. It accepts operand pairs `(a, b)` from upstream over a valid/ready handshake and drives them into the pipeline. It tracks in-flight operations with a tagged valid shift register and captures each returning `c` into an output FIFO. Downstream is served over valid/ready. Credit accounting guarantees that no pipeline result is ever dropped under backpressure.

## Interface
Parameters:
- `LATENCY`, default 10: cycles from `pipe_a`/`pipe_b` presented to `pipe_c` valid; equals mult latency + add latency of the pipeline.
- `FIFO_DEPTH`, default 16: result FIFO entries; power of two; must be ≥ 1.
- `TAG_W`, default 8: width of the user tag carried alongside each operation.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: upstream operand pair valid.
- `in_ready`  out  1: issuer can accept.
- `in_a`, `in_b`  in  96 each (`p_float3`): operand vectors; three 32-bit `p_float` components x, y, z.
- `in_tag`  in  `TAG_W`: user tag.
- `pipe_a`, `pipe_b`  out  96 each (`p_float3`): registered operands to the pipeline.
- `pipe_c`  in  96 (`p_float3`): pipeline result.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: downstream accepts.
- `out_c`  out  96 (`p_float3`): result vector.
- `out_tag`  out  `TAG_W`: tag matching `out_c`.

## Operation
- **Accept:** `acc = in_valid & in_ready`. On `acc`, `pipe_a`/`pipe_b` load `in_a`/`in_b`. Otherwise they hold their value; the pipeline output for held operands is ignored.
- **Tracking:** `vld_sr[LATENCY:0]` and `tag_sr` shift every cycle.
  - Stage 0 loads `acc` and `in_tag`.
  - The element leaving the last stage marks `pipe_c` as valid that cycle (`arr`).
- **Capture:** on `arr`, `{pipe_c, tag}` is written at `wr_ptr`, which then increments modulo `FIFO_DEPTH`. The write always succeeds, because credit accounting reserves the slot.
- **Output:**
  - `out_valid = (count != 0)`.
  - `out_c`/`out_tag` show `mem[rd_ptr]`, read directly from the memory (first-word fall-through).
  - On `out_valid & out_ready`, `rd_ptr` increments.
- **Credits:**
  - `used = count + inflight`, where `inflight` is the number of set bits in `vld_sr`.
  - `in_ready = rst_n & (used < FIFO_DEPTH)`; registered-state only, no combinational path from `in_valid` or `out_ready`.
  - `used_next = used + acc − pop`. An arrival moves one unit from `inflight` to `count` and leaves `used` unchanged.
- **Simultaneous write and pop:** `count` unchanged, both pointers advance. Write and pop at the same address are impossible while `count > 0` because of the write/read ordering.
- **Boundary conditions:**
  - Full FIFO (`used == FIFO_DEPTH`): `in_ready = 0`. In-flight results still land.
  - Empty FIFO: a pop request is ignored.
  - Pointers wrap naturally, since `FIFO_DEPTH` is a power of two.
- **Reset** (`rst_n = 0` at an edge):
  - `vld_sr`, `count`, `wr_ptr`, `rd_ptr` go to 0; `pipe_a`/`pipe_b` go to 0.
  - `out_valid = 0`, `in_ready = 0` while reset is held.
  - Operations in flight when reset asserts are discarded; their `pipe_c` values are never captured.

## Timing
- Accept at edge *t* → `pipe_a`/`pipe_b` valid in cycle *t+1* → `pipe_c` valid in cycle *t+1+LATENCY* → captured at that cycle's closing edge → `out_valid` high in cycle *t+2+LATENCY*.
- Minimum accept-to-output latency: `LATENCY + 2` cycles.
- Throughput: one operation per cycle sustained when `out_ready = 1` and `FIFO_DEPTH ≥ LATENCY + 2`. A smaller depth throttles throughput to `FIFO_DEPTH / (LATENCY + 2)`.
- Results leave in strict issue order; the tag is preserved.
- Reset values:
  - `in_ready`, `out_valid`: 0.
  - `pipe_a`, `pipe_b`: 0.
  - `out_c`, `out_tag`: don't-care while `out_valid = 0`.
- First accept is possible in the first cycle after `rst_n` rises.

## Test plan
- **Single op:** `a = (1,0,0)` = `{0x3F800000, 0, 0}`, `b = (0,1,0)`, tag `0x5A`, `out_ready = 1` → `out_valid` exactly `LATENCY + 2` cycles after accept, `out_c = (0,0,0x3F800000)`, `out_tag = 0x5A`, one beat only.
- **Back-to-back streaming:** 64 random pairs issued every cycle, `out_ready = 1` → `in_ready` never drops, results in order with matching tags, bit-exact to the reference-model cross product.
- **Backpressure fill:** `out_ready = 0`, continuous `in_valid` → exactly `FIFO_DEPTH` (16) accepts, then `in_ready = 0`. All 16 results land with no loss. Raising `out_ready` drains 16 in order and re-enables `in_ready`.
- **Simultaneous accept and pop at full credit:** `used = 16`, `out_ready = 1` → one pop per cycle restores one credit the next cycle. `count` never exceeds 16, and the pointers wrap past 15→0 correctly over 40 operations.
- **Reset mid-flight:** 5 ops in flight plus 3 in the FIFO, then `rst_n = 0` for 1 cycle → `out_valid = 0` and no later capture of the 5 stale results. A new op after reset returns `LATENCY + 2` cycles later with the correct value.
- **Tag/ordering under random stalls:** random `in_valid`/`out_ready` at 50% for 1000 ops → no drop, no duplicate, tags in sequence.
